cmd_processor_engines_integration: RTL and testbench
====================================================

CMD_PROCESSOR_ENGINES_INTEGRATION -- requirements
Module: cmd_processor_engines_integration

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ROM_DEPTH, default 32, SHALL set the number of 32-bit command ROM entries.
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge clock for all state.
REQ-004 Port rst_, input, 1 bit, SHALL be the synchronous active-high reset (rst_=1 resets).
REQ-005 Port busy, output, 1 bit, SHALL be high while the program is executing.
REQ-006 Port done, output, 1 bit, SHALL be high once the block has halted.
REQ-007 Port error, output, 1 bit, SHALL be a sticky flag for an undefined opcode.
REQ-008 Port cmds_executed, output, 8 bits, SHALL count completed non-HALT commands.
REQ-009 Port pixels_written, output, 16 bits, SHALL count framebuffer writes.

Function
REQ-010 The block SHALL contain:
- an internal command ROM, cmd_rom[0:ROM_DEPTH-1], with synchronous read;
- a 16x16 8-bit framebuffer, fb_mem[0:255], at address y*16+x;
- a current colour register, color;
- a program counter, pc.
REQ-011 Opcode is cmd[31:28]:
- 0 NOP;
- 1 SETCOLOR, color<=cmd[7:0];
- 2 PIXEL, x=cmd[3:0], y=cmd[7:4];
- 3 RECT, x0=cmd[3:0], y0=cmd[7:4], x1=cmd[11:8], y1=cmd[15:12], inclusive bounds;
- 4 CLEAR, fills the whole buffer;
- F HALT;
- all others are executed as NOP and set error.
REQ-012 FSM states SHALL be FETCH, DECODE, FILL and HALTED.
- FETCH presents pc to the ROM and goes to DECODE.
- DECODE latches the fields, then goes to FILL, FETCH (pc+1) or HALTED.
REQ-013 PIXEL, RECT and CLEAR SHALL all be executed by the FILL engine.
- The engine writes one pixel per cycle with the current colour.
- Order is raster order, x fastest, from (x0,y0) to (x1,y1).
- PIXEL uses x0=x1=x, y0=y1=y; CLEAR uses (0,0)-(15,15).
REQ-014 On the cycle it writes the last pixel, FILL SHALL go to FETCH with pc+1.
REQ-015 Command latency SHALL be:
- NOP/SETCOLOR: 2 cycles;
- PIXEL: 3 cycles;
- RECT: 2+(x1-x0+1)*(y1-y0+1) cycles;
- CLEAR: 258 cycles.
REQ-016 A RECT with x1<x0 or y1<y0 SHALL write nothing and still count as executed (2 cycles).
REQ-017 HALT SHALL enter HALTED. HALTED is terminal until reset: done=1, busy=0, no ROM reads and no writes.
REQ-018 If a non-HALT command at pc=ROM_DEPTH-1 completes, the block SHALL enter HALTED; pc never wraps.
REQ-019 Counters SHALL saturate at their all-ones value.
REQ-020 The default ROM program SHALL be as follows, with all other entries HALT (0xF0000000):
- 0: 0x10000000;
- 1: 0x40000000;
- 2: 0x1000001F;
- 3: 0x20000032;
- 4: 0x100000A5;
- 5: 0x30005644;
- 6: 0xF0000000.

Reset
REQ-021 While rst_=1 at a clock edge, the block SHALL hold:
- state=FETCH, pc=0, color=0x00;
- busy=0, done=0, error=0;
- cmds_executed=0, pixels_written=0.
REQ-022 fb_mem contents SHALL NOT be cleared by reset.
REQ-023 Reset mid-command SHALL abort it immediately, with no further writes.
REQ-024 busy SHALL rise on the first edge with rst_=0, and execution SHALL restart from pc=0.

Verification
REQ-025 Default program from reset release -> results below:
- done=1 within 280 cycles;
- cmds_executed=6, pixels_written=263, error=0;
- fb_mem[3*16+2]=0x1F;
- fb_mem[y*16+x]=0xA5 for x=4..6, y=4..5;
- every other pixel 0x00.
REQ-026 Reset pulse (rst_ 1 for 3 cycles, 0 for 3 cycles, then 1 again) -> results below:
- outputs return to reset values at the first edge with rst_=1;
- pixels_written<=1;
- after final release, the full program reruns to the REQ-025 result.
REQ-027 ROM entry 0x30000023 (x1<x0), then HALT -> pixels_written unchanged, cmds_executed=1, done=1.
REQ-028 ROM entry 0x70000000, then HALT -> error=1 and stays 1 after done, with no framebuffer writes.
REQ-029 ROM_DEPTH=4 with no HALT -> HALTED after pc=3 completes; done=1, cmds_executed=4.
REQ-030 Reset asserted during CLEAR at pixel 100 -> writes stop at once; fb pixels 100..255 keep their prior values until rerun.

Source files
------------

// File: rtl/cmd_processor_engines_integration.sv
// Command processor: fetches 32-bit commands from an internal ROM and drives a
// raster fill engine that paints a 16x16 8-bit framebuffer one pixel per cycle.
module cmd_processor_engines_integration #(
  parameter int ROM_DEPTH = 32,
  parameter logic [7:0][31:0] ROM_PROG = {
    32'hF0000000, 32'hF0000000, 32'h30005644, 32'h100000A5,
    32'h20000032, 32'h1000001F, 32'h40000000, 32'h10000000
  }
) (
  input  logic        clk,
  input  logic        rst_,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  cmds_executed,
  output logic [15:0] pixels_written
);

  localparam int PC_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [31:0] CMD_HALT = 32'hF0000000;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_SETCOLOR = 4'h1;
  localparam logic [3:0] OP_PIXEL    = 4'h2;
  localparam logic [3:0] OP_RECT     = 4'h3;
  localparam logic [3:0] OP_CLEAR    = 4'h4;
  localparam logic [3:0] OP_HALT     = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_FILL, S_HALTED} state_t;

  logic [31:0] cmd_rom [0:ROM_DEPTH-1];
  logic [7:0]  fb_mem  [0:255];

  state_t          r_state;
  state_t          w_state_nx;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_cmd;
  logic [7:0]      r_color;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic [7:0]      r_cmds;
  logic [15:0]     r_pix;
  logic [3:0]      r_x, r_y, r_x0, r_x1, r_y1;

  logic [3:0] w_op;
  logic [3:0] w_x0, w_y0, w_x1, w_y1;
  logic       w_empty;
  logic       w_pc_last;
  logic       w_fill_last;
  logic       w_complete;
  logic       w_start_fill;
  logic       w_set_err;
  logic       w_unused;

  // Entries beyond the programmable window read as HALT.
  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    if (i < 8) begin : g_prog
      assign cmd_rom[i] = ROM_PROG[i];
    end else begin : g_halt
      assign cmd_rom[i] = CMD_HALT;
    end
  end

  assign w_op        = r_cmd[31:28];
  assign w_pc_last   = (r_pc == PC_W'(ROM_DEPTH - 1));
  assign w_fill_last = (r_x == r_x1) && (r_y == r_y1);
  assign w_empty     = (w_x1 < w_x0) || (w_y1 < w_y0);
  assign w_unused    = ^r_cmd[27:16];

  always_comb begin
    w_x0 = r_cmd[3:0];
    w_y0 = r_cmd[7:4];
    w_x1 = r_cmd[3:0];
    w_y1 = r_cmd[7:4];
    if (w_op == OP_RECT) begin
      w_x1 = r_cmd[11:8];
      w_y1 = r_cmd[15:12];
    end else if (w_op == OP_CLEAR) begin
      w_x0 = 4'd0;
      w_y0 = 4'd0;
      w_x1 = 4'd15;
      w_y1 = 4'd15;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_complete   = 1'b0;
    w_start_fill = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_FETCH: w_state_nx = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_HALT: w_state_nx = S_HALTED;
          OP_NOP, OP_SETCOLOR: w_complete = 1'b1;
          OP_PIXEL, OP_RECT, OP_CLEAR: begin
            if (w_empty) begin
              w_complete = 1'b1;
            end else begin
              w_start_fill = 1'b1;
              w_state_nx   = S_FILL;
            end
          end
          default: begin
            w_complete = 1'b1;
            w_set_err  = 1'b1;
          end
        endcase
      end
      S_FILL: w_complete = w_fill_last;
      default: w_state_nx = S_HALTED;
    endcase
    // A finished command at the last ROM slot halts instead of wrapping pc.
    if (w_complete) w_state_nx = w_pc_last ? S_HALTED : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_color <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_cmds  <= 8'h00;
      r_pix   <= 16'h0000;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_HALTED);
      r_done  <= (w_state_nx == S_HALTED);
      if (r_state == S_DECODE && w_op == OP_SETCOLOR) r_color <= r_cmd[7:0];
      if (w_set_err) r_error <= 1'b1;
      if (w_complete) begin
        if (!w_pc_last) r_pc <= r_pc + PC_W'(1);
        if (r_cmds != 8'hFF) r_cmds <= r_cmds + 8'd1;
      end
      if (r_state == S_FILL && r_pix != 16'hFFFF) r_pix <= r_pix + 16'd1;
    end
  end

  // Datapath and framebuffer carry no reset; writes are blocked while rst_ is high.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH) r_cmd <= cmd_rom[r_pc];
    if (w_start_fill) begin
      r_x  <= w_x0;
      r_y  <= w_y0;
      r_x0 <= w_x0;
      r_x1 <= w_x1;
      r_y1 <= w_y1;
    end else if (r_state == S_FILL) begin
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + 4'd1;
      end else begin
        r_x <= r_x + 4'd1;
      end
    end
    if (!rst_ && r_state == S_FILL) fb_mem[{r_y, r_x}] <= r_color;
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign cmds_executed  = r_cmds;
  assign pixels_written = r_pix;

endmodule

// File: tb/tb_cmd_processor_engines_integration.sv
// Bench for cmd_processor_engines_integration: default program, reset pulses at
// random points against a command-level timing/paint model, and corner programs.
module tb_cmd_processor_engines_integration;

  localparam logic [31:0] HALT = 32'hF0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rst;
  wire  [4:0] busy, done, err;
  wire  [7:0]  cmds [5];
  wire  [15:0] pix  [5];

  int n_assert = 0;
  int n_fail   = 0;

  // 0: default program, 1: empty rect, 2: bad opcode, 3: depth 4, 4: double clear
  cmd_processor_engines_integration dut_main (
    .clk(clk), .rst_(rst[0]), .busy(busy[0]), .done(done[0]), .error(err[0]),
    .cmds_executed(cmds[0]), .pixels_written(pix[0]));
  cmd_processor_engines_integration #(.ROM_PROG({{7{HALT}}, 32'h30000023})) dut_rect (
    .clk(clk), .rst_(rst[1]), .busy(busy[1]), .done(done[1]), .error(err[1]),
    .cmds_executed(cmds[1]), .pixels_written(pix[1]));
  cmd_processor_engines_integration #(.ROM_PROG({{7{HALT}}, 32'h70000000})) dut_err (
    .clk(clk), .rst_(rst[2]), .busy(busy[2]), .done(done[2]), .error(err[2]),
    .cmds_executed(cmds[2]), .pixels_written(pix[2]));
  cmd_processor_engines_integration #(.ROM_DEPTH(4)) dut_d4 (
    .clk(clk), .rst_(rst[3]), .busy(busy[3]), .done(done[3]), .error(err[3]),
    .cmds_executed(cmds[3]), .pixels_written(pix[3]));
  cmd_processor_engines_integration #(.ROM_PROG({{4{HALT}}, 32'h40000000, 32'h10000000,
                                                 32'h40000000, 32'h1000005A})) dut_clr (
    .clk(clk), .rst_(rst[4]), .busy(busy[4]), .done(done[4]), .error(err[4]),
    .cmds_executed(cmds[4]), .pixels_written(pix[4]));

  // Command-level reference model of the default program.
  logic [31:0] prog [0:31];
  int          t_start [0:31];
  int          lat [0:31];
  int          npx [0:31];
  int          n_cmd;
  int          t_total;
  logic [7:0]  exp_fb [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    int t;
    logic [7:0] col;
    logic [3:0] op;
    int x0, y0, x1, y1;
    for (int i = 0; i < 32; i++) prog[i] = HALT;
    prog[0] = 32'h10000000; prog[1] = 32'h40000000; prog[2] = 32'h1000001F;
    prog[3] = 32'h20000032; prog[4] = 32'h100000A5; prog[5] = 32'h30005644;
    for (int i = 0; i < 256; i++) exp_fb[i] = 8'h00;
    t = 0; col = 8'h00; n_cmd = 0; t_total = 0;
    for (int pc = 0; pc < 32; pc++) begin
      op = prog[pc][31:28];
      if (op == 4'hF) begin
        t_total = t + 2;
        break;
      end
      x0 = 0; y0 = 0; x1 = -1; y1 = -1;
      if (op == 4'h1) col = prog[pc][7:0];
      if (op == 4'h2) begin
        x0 = prog[pc][3:0]; y0 = prog[pc][7:4]; x1 = x0; y1 = y0;
      end
      if (op == 4'h3) begin
        x0 = prog[pc][3:0]; y0 = prog[pc][7:4]; x1 = prog[pc][11:8]; y1 = prog[pc][15:12];
      end
      if (op == 4'h4) begin
        x0 = 0; y0 = 0; x1 = 15; y1 = 15;
      end
      npx[n_cmd] = 0;
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++) begin
          exp_fb[y*16 + x] = col;
          npx[n_cmd]++;
        end
      t_start[n_cmd] = t;
      lat[n_cmd] = 2 + npx[n_cmd];
      t = t + lat[n_cmd];
      n_cmd++;
      t_total = t;
    end
  endtask

  task automatic model_at(input int c, output int ep, output int ec);
    int w;
    ep = 0; ec = 0;
    for (int k = 0; k < n_cmd; k++) begin
      w = c - t_start[k] - 2;
      if (w < 0) w = 0;
      if (w > npx[k]) w = npx[k];
      ep += w;
      if (t_start[k] + lat[k] <= c) ec++;
    end
  endtask

  task automatic check_reset_vals(input string tag, input int d);
    check({tag, "_busy"}, 32'(busy[d]), 0);
    check({tag, "_done"}, 32'(done[d]), 0);
    check({tag, "_err"},  32'(err[d]),  0);
    check({tag, "_cmds"}, 32'(cmds[d]), 0);
    check({tag, "_pix"},  32'(pix[d]),  0);
  endtask

  task automatic run_main_to_done(input string tag);
    int n = 0;
    rst[0] = 1'b0;
    while (!done[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'(t_total));
    check({tag, "_cmds"},   32'(cmds[0]), 6);
    check({tag, "_pix"},    32'(pix[0]), 263);
    check({tag, "_err"},    32'(err[0]), 0);
    check({tag, "_busy"},   32'(busy[0]), 0);
  endtask

  task automatic check_main_image(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (dut_main.fb_mem[i] !== exp_fb[i]) bad++;
    check({tag, "_image_bad"}, 32'(bad), 0);
  endtask

  initial begin
    int c, ep, ec, n, bad;
    build_model();
    rst = 5'b11111;
    repeat (3) @(negedge clk);
    check_reset_vals("rst", 0);

    rst[3:1] = 3'b000;
    run_main_to_done("run1");
    check_main_image("run1");
    check("run1_fb_pixel", 32'(dut_main.fb_mem[3*16+2]), 32'h1F);
    check("run1_fb_rect", 32'(dut_main.fb_mem[5*16+6]), 32'hA5);
    repeat (20) @(negedge clk);
    check("halted_pix", 32'(pix[0]), 263);
    check("halted_done", 32'(done[0]), 1);

    rst[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("pulse_a", 0);
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pulse_pix_le1", 32'(pix[0] <= 16'd1), 1);
    check("pulse_busy", 32'(busy[0]), 1);
    rst[0] = 1'b1;
    @(negedge clk);
    check_reset_vals("pulse_b", 0);
    run_main_to_done("rerun");
    check_main_image("rerun");

    for (int k = 0; k < 6; k++) begin
      rst[0] = 1'b1;
      @(negedge clk);
      c = $urandom_range(1, t_total + 4);
      rst[0] = 1'b0;
      repeat (c) @(negedge clk);
      model_at(c, ep, ec);
      check($sformatf("rand%0d_pix_c%0d", k, c), 32'(pix[0]), 32'(ep));
      check($sformatf("rand%0d_cmds_c%0d", k, c), 32'(cmds[0]), 32'(ec));
      check($sformatf("rand%0d_busy_c%0d", k, c), 32'(busy[0]), 32'(c < t_total));
      check($sformatf("rand%0d_done_c%0d", k, c), 32'(done[0]), 32'(c >= t_total));
      rst[0] = 1'b1;
      @(negedge clk);
      check_reset_vals($sformatf("rand%0d_abort", k), 0);
    end
    run_main_to_done("final");
    check_main_image("final");

    check("rect_cmds", 32'(cmds[1]), 1);
    check("rect_pix",  32'(pix[1]), 0);
    check("rect_done", 32'(done[1]), 1);
    check("rect_err",  32'(err[1]), 0);
    check("err_flag",  32'(err[2]), 1);
    check("err_done",  32'(done[2]), 1);
    check("err_pix",   32'(pix[2]), 0);
    check("err_cmds",  32'(cmds[2]), 1);
    check("d4_done",   32'(done[3]), 1);
    check("d4_busy",   32'(busy[3]), 0);
    check("d4_cmds",   32'(cmds[3]), 4);
    check("d4_pix",    32'(pix[3]), 257);

    rst[4] = 1'b0;
    n = 0;
    while (pix[4] != 16'd356 && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("clr_reach_p100", 32'(pix[4]), 356);
    rst[4] = 1'b1;
    @(negedge clk);
    check_reset_vals("clr_abort", 4);
    repeat (5) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut_clr.fb_mem[i] !== ((i < 100) ? 8'h00 : 8'h5A)) bad++;
    check("clr_abort_image_bad", 32'(bad), 0);
    rst[4] = 1'b0;
    n = 0;
    while (!done[4] && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("clr_cycles", 32'(n), 2 + 258 + 2 + 258 + 2);
    check("clr_pix",  32'(pix[4]), 512);
    check("clr_cmds", 32'(cmds[4]), 4);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut_clr.fb_mem[i] !== 8'h00) bad++;
    check("clr_rerun_image_bad", 32'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
